map_path_writer: RTL
====================

MAP_PATH_WRITER -- requirements
Module: map_path_writer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, location FIFO entries (power of 2, 2..16).
REQ-002 Parameter: CLEAR_DATA, 2'b00, map value written during a clear sweep.
REQ-003 Port: clk  input  1  single system clock; all logic on the rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: loc_x  input  7  robot world column, 0..127.
REQ-006 Port: loc_y  input  7  robot world row, 0..127.
REQ-007 Port: loc_color  input  2  map value to paint at the location.
REQ-008 Port: loc_valid  input  1  location sample offered this cycle.
REQ-009 Port: loc_ready  output  1  FIFO can accept a sample (count < FIFO_DEPTH).
REQ-010 Port: clear_req  input  1  single-cycle pulse; request a full-map clear.
REQ-011 Port: wr_addr  output  14  map RAM write address.
REQ-012 Port: wr_data  output  2  map RAM write data.
REQ-013 Port: wr_en  output  1  map RAM write strobe, one write per high cycle.
REQ-014 Port: busy  output  1  clear sweep in progress.
REQ-015 Port: overflow  output  1  sticky; a sample was offered while loc_ready was low.
REQ-016 Port: fifo_count  output  5  current FIFO occupancy.

Function
REQ-017 Address mapping SHALL be wr_addr = loc_y*128 + loc_x, i.e. {loc_y, loc_x}; this matches the video read-side mapping (row*128 + col).
REQ-018 Sample accepted at a rising edge where loc_valid=1 and loc_ready=1; {loc_y, loc_x, loc_color} pushed into the FIFO.
REQ-019 loc_ready SHALL derive from the registered count only; a push is refused when the FIFO is full, even if a pop occurs in the same cycle.
REQ-020 loc_valid=1 with loc_ready=0: sample dropped, overflow set to 1 and held until reset or an accepted clear_req.
REQ-021 FSM states: IDLE, WRITE, CLEAR.
REQ-022 IDLE: clear pending -> CLEAR; else FIFO non-empty -> pop head -> WRITE; else remain in IDLE.
REQ-023 WRITE: drive wr_addr/wr_data from the popped entry with wr_en=1 for one cycle; pop the next entry if available (one write per clock sustained); otherwise return to IDLE.
REQ-024 Latency: a sample accepted at edge N with an empty FIFO in IDLE SHALL show wr_en=1 in the cycle following edge N+1.
REQ-025 Duplicate suppression: a popped entry whose address and colour equal the last entry written SHALL be discarded (wr_en stays 0) and consume one cycle.
REQ-026 Last-written register is invalid after reset and after every clear; the first entry following either is always written.
REQ-027 clear_req accepted in any state except CLEAR; it sets a pending flag; a WRITE in progress completes its current write first.
REQ-028 CLEAR: busy=1, wr_en=1 every cycle, wr_data=CLEAR_DATA, wr_addr counts 0..16383 with one address per cycle (exactly 16384 writes), then returns to IDLE with busy=0.
REQ-029 clear_req during CLEAR is ignored (it does not restart the sweep and does not clear overflow).
REQ-030 During CLEAR the FIFO keeps accepting samples until full; they are written after the sweep ends.
REQ-031 clear_req and loc_valid in the same cycle: the sample is enqueued and the clear runs first.
REQ-032 Clear takes priority over a non-empty FIFO in IDLE.
REQ-033 All outputs SHALL be registered; wr_addr/wr_data hold their last values while wr_en=0.

Reset
REQ-034 reset_n=0 asynchronously forces: state IDLE, FIFO empty, fifo_count=0, loc_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, overflow=0, clear pending=0, last-written invalid.
REQ-035 Reset asserted mid-CLEAR or mid-WRITE aborts the operation; no write resumes after release.
REQ-036 The first edge after reset_n rises SHALL accept loc_valid normally.

Verification
REQ-037 Single sample x=5, y=3, colour=2 -> one wr_en pulse with wr_addr=389 and wr_data=2, at the latency in REQ-024.
REQ-038 Burst of 6 distinct samples, one per cycle, FIFO_DEPTH=4, no writes stalled -> all 6 written back-to-back in order, overflow=0; with a forced 4-deep backlog, the fifth offered sample -> loc_ready=0, dropped, overflow=1.
REQ-039 Same location (127,127) with the same colour offered 3 times -> exactly one write, wr_addr=16383.
REQ-040 clear_req -> busy high for 16384 cycles, writes cover addresses 0..16383 with data=CLEAR_DATA; 2 samples offered mid-sweep -> written immediately after busy falls; overflow cleared by the clear.
REQ-041 reset_n pulsed low at sweep address 100 -> all outputs at reset values immediately, no further writes, FIFO empty.

Source files
------------

// File: rtl/map_path_writer.sv
// Map path writer: buffers robot location samples in a small FIFO and paints
// them into a 128x128x2-bit map RAM; also performs full-map clear sweeps.
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   loc_x, loc_y          sample column/row (0..127)
//   loc_color             map value to paint
//   loc_valid, loc_ready  sample handshake (ready from registered count)
//   clear_req             single-cycle full-map clear request
//   wr_addr, wr_data      map RAM write address ({row, col}) and data
//   wr_en                 map RAM write strobe
//   busy                  clear sweep in progress
//   overflow              sticky: sample offered while not ready
//   fifo_count            current FIFO occupancy
module map_path_writer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] CLEAR_DATA = 2'b00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  loc_x,
    input  logic [6:0]  loc_y,
    input  logic [1:0]  loc_color,
    input  logic        loc_valid,
    output logic        loc_ready,
    input  logic        clear_req,
    output logic [13:0] wr_addr,
    output logic [1:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        overflow,
    output logic [4:0]  fifo_count
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } state_t;

    state_t state_q, state_d;

    // FIFO entries are {y, x, colour}, so the top 14 bits are the RAM address.
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [4:0]    count;
    logic          push, pop;
    logic [15:0]   head;

    logic [13:0] wr_addr_q, wr_addr_d;
    logic [1:0]  wr_data_q, wr_data_d;
    logic        wr_en_q, wr_en_d;
    logic        busy_q, busy_d;
    logic        ovf_q;
    logic        pend_q, pend_clr;
    logic        clr_acc;
    logic [15:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic        dispatch, dup;

    assign loc_ready  = (count < 5'(FIFO_DEPTH));
    assign push       = loc_valid & loc_ready;
    assign head       = mem[rd_ptr];
    assign dup        = last_vld_q && (head == last_q);
    assign clr_acc    = clear_req && (state_q != CLEAR);

    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign wr_en      = wr_en_q;
    assign busy       = busy_q;
    assign overflow   = ovf_q;
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {loc_y, loc_x, loc_color};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // A new clear_req on the edge that launches a sweep merges into it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (pend_clr)     pend_q <= 1'b0;
            else if (clr_acc) pend_q <= 1'b1;
            if (loc_valid && !loc_ready) ovf_q <= 1'b1;
            else if (clr_acc)            ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end

    // IDLE and WRITE share the dispatch decision; the last sweep edge also
    // dispatches so buffered samples follow the clear with no gap.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        busy_d     = 1'b0;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        pop        = 1'b0;
        pend_clr   = 1'b0;
        dispatch   = 1'b0;

        unique case (state_q)
            IDLE, WRITE: dispatch = 1'b1;
            CLEAR: begin
                if (wr_addr_q != 14'h3fff) begin
                    busy_d    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_data_d = CLEAR_DATA;
                    wr_addr_d = wr_addr_q + 14'd1;
                end else begin
                    state_d  = IDLE;
                    dispatch = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (dispatch) begin
            if (pend_q) begin
                state_d    = CLEAR;
                pend_clr   = 1'b1;
                busy_d     = 1'b1;
                wr_en_d    = 1'b1;
                wr_addr_d  = '0;
                wr_data_d  = CLEAR_DATA;
                last_vld_d = 1'b0;
            end else if (count != 5'd0) begin
                state_d = WRITE;
                pop     = 1'b1;
                if (!dup) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = head[15:2];
                    wr_data_d  = head[1:0];
                    last_d     = head;
                    last_vld_d = 1'b1;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

endmodule
